// File: rtl/turn_sched_pkg.sv
// Shared definitions for the turn scheduler: field widths and FSM state encoding.
package turn_sched_pkg;

    localparam int SCORE_W = 4;
    localparam int ROUND_W = 4;
    localparam int SEC_W   = 4;
    localparam int PID_W   = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TURN  = 3'd1,
        ST_CHECK = 3'd2,
        ST_NEXT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/turn_sched_if.sv
// Bundle between the player-side inputs/verifier and the turn scheduler.
interface turn_sched_if #(parameter int NUM_PLAYERS = 4);
    import turn_sched_pkg::*;

    // Handshake: every input strobe (start, req, one_sec, match_valid) is a
    // single-cycle pulse sampled on posedge clk with no ready/backpressure;
    // match is only meaningful in a cycle where match_valid is high.
    logic                           start;
    logic [NUM_PLAYERS-1:0]         req;
    logic                           one_sec;
    logic                           match_valid;
    logic                           match;

    logic [NUM_PLAYERS-1:0]         grant;
    logic                           load_en;
    logic                           clear_load;
    logic [PID_W-1:0]               cur_player;
    logic [ROUND_W-1:0]             round_num;
    logic [SEC_W-1:0]               secs_left;
    logic [SCORE_W*NUM_PLAYERS-1:0] scores;
    logic                           game_over;
    logic [PID_W-1:0]               winner;
    state_t                         state;

    modport master (
        output start, req, one_sec, match_valid, match,
        input  grant, load_en, clear_load, cur_player, round_num, secs_left,
               scores, game_over, winner, state
    );

    modport slave (
        input  start, req, one_sec, match_valid, match,
        output grant, load_en, clear_load, cur_player, round_num, secs_left,
               scores, game_over, winner, state
    );

endinterface

// File: rtl/turn_sched_timer.sv
// Per-turn seconds counter: loads TURN_SECS, counts down on ticks unless held.
module turn_timer
    import turn_sched_pkg::*;
#(
    parameter int TURN_SECS = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             tick,
    input  logic             hold,
    output logic [SEC_W-1:0] secs_left,
    output logic             expire
);

    assign expire = tick && !hold && (secs_left == SEC_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            secs_left <= '0;
        end else if (load) begin
            secs_left <= SEC_W'(TURN_SECS);
        end else if (tick && !hold && (secs_left != '0)) begin
            secs_left <= secs_left - SEC_W'(1);
        end
    end

endmodule

// File: rtl/turn_sched.sv
// Round-robin turn scheduler sharing one guess datapath among NUM_PLAYERS,
// with timed turns, per-player saturating scores and winner selection.
module turn_sched
    import turn_sched_pkg::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int TURN_SECS   = 9,
    parameter int MAX_ROUNDS  = 3,
    parameter int WIN_SCORE   = 15
) (
    input  logic         clk,
    input  logic         rst,
    turn_sched_if.slave  bus
);

    localparam logic [NUM_PLAYERS-1:0] FIRST_GRANT = NUM_PLAYERS'(1);

    state_t                         state;
    logic [NUM_PLAYERS-1:0]         grant_q;
    logic [PID_W-1:0]               cur_q;
    logic [ROUND_W-1:0]             round_q;
    logic [SCORE_W*NUM_PLAYERS-1:0] scores_q;
    logic                           load_en_q;
    logic                           clear_q;
    logic                           over_q;
    logic [PID_W-1:0]               winner_q;

    logic                           tmr_load;
    logic                           tmr_hold;
    logic                           expire;
    logic [SEC_W-1:0]               secs;

    logic                           granted_req;
    logic                           any_win;
    logic [PID_W-1:0]               best_pid;
    logic [SCORE_W-1:0]             best_score;
    logic [SCORE_W-1:0]             cur_score;
    logic                           last_turn;

    // The timer reloads while NEXT is shown, so the following turn opens at TURN_SECS.
    always_comb begin
        tmr_load = (state == ST_NEXT) ||
                   (((state == ST_IDLE) || (state == ST_DONE)) && bus.start);
        tmr_hold = (state != ST_TURN);
    end

    turn_timer #(.TURN_SECS(TURN_SECS)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (tmr_load),
        .tick      (bus.one_sec),
        .hold      (tmr_hold),
        .secs_left (secs),
        .expire    (expire)
    );

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        best_pid   = '0;
        best_score = scores_q[SCORE_W-1:0];
        any_win    = (scores_q[SCORE_W-1:0] >= SCORE_W'(WIN_SCORE));
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (scores_q[i*SCORE_W +: SCORE_W] > best_score) begin
                best_score = scores_q[i*SCORE_W +: SCORE_W];
                best_pid   = PID_W'(i);
            end
            if (scores_q[i*SCORE_W +: SCORE_W] >= SCORE_W'(WIN_SCORE)) begin
                any_win = 1'b1;
            end
        end
    end

    always_comb begin
        granted_req = |(bus.req & grant_q);
        cur_score   = scores_q[cur_q*SCORE_W +: SCORE_W];
        last_turn   = (cur_q == PID_W'(NUM_PLAYERS - 1)) &&
                      (round_q == ROUND_W'(MAX_ROUNDS));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_q   <= '0;
            cur_q     <= '0;
            round_q   <= '0;
            scores_q  <= '0;
            load_en_q <= 1'b0;
            clear_q   <= 1'b0;
            over_q    <= 1'b0;
            winner_q  <= '0;
        end else begin
            load_en_q <= 1'b0;
            clear_q   <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        clear_q  <= 1'b1;
                        scores_q <= '0;
                        cur_q    <= '0;
                        round_q  <= ROUND_W'(1);
                        over_q   <= 1'b0;
                        winner_q <= '0;
                        grant_q  <= FIRST_GRANT;
                        state    <= ST_TURN;
                    end
                end
                ST_TURN: begin
                    // A granted press beats a tick expiring in the same cycle.
                    if (granted_req) begin
                        load_en_q <= 1'b1;
                        state     <= ST_CHECK;
                    end else if (expire) begin
                        grant_q <= '0;
                        clear_q <= 1'b1;
                        state   <= ST_NEXT;
                    end
                end
                ST_CHECK: begin
                    if (bus.match_valid) begin
                        if (bus.match && (cur_score != '1)) begin
                            scores_q[cur_q*SCORE_W +: SCORE_W] <= cur_score + SCORE_W'(1);
                        end
                        grant_q <= '0;
                        clear_q <= 1'b1;
                        state   <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (any_win || last_turn) begin
                        over_q   <= 1'b1;
                        winner_q <= best_pid;
                        state    <= ST_DONE;
                    end else if (cur_q == PID_W'(NUM_PLAYERS - 1)) begin
                        round_q <= round_q + ROUND_W'(1);
                        cur_q   <= '0;
                        grant_q <= FIRST_GRANT;
                        state   <= ST_TURN;
                    end else begin
                        cur_q   <= cur_q + PID_W'(1);
                        grant_q <= FIRST_GRANT << (cur_q + PID_W'(1));
                        state   <= ST_TURN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.grant      = grant_q;
    assign bus.load_en    = load_en_q;
    assign bus.clear_load = clear_q;
    assign bus.cur_player = cur_q;
    assign bus.round_num  = round_q;
    assign bus.secs_left  = secs;
    assign bus.scores     = scores_q;
    assign bus.game_over  = over_q;
    assign bus.winner     = winner_q;
    assign bus.state      = state;

endmodule
